// File: rtl/rt_uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
package rt_uart_pkg;

  localparam int OversampleRate = 16;
  localparam int SamplePoint    = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/rt_uart_rx_fifo.sv
// Receive byte FIFO; head is visible combinationally, one-cycle write.
// A push while full succeeds only when a pop happens in the same cycle.
module rt_uart_rx_fifo #(
  parameter int FifoDepth = 8,
  parameter int Width     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(FifoDepth):0] count_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;

  logic [Width-1:0] r_mem [FifoDepth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CW'(FifoDepth));
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  // Empty reads as zero so the head byte is clean after reset.
  assign data_o    = empty_o ? '0 : r_mem[r_rd_ptr];
  assign count_o   = r_count;

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/rt_uart_rx.sv
// 16x-oversampled UART receiver (8 data bits, optional parity) feeding a byte FIFO.
// Byte enters the FIFO at the mid-stop-bit sample; a full FIFO with no pop drops it and flags overrun.
module rt_uart_rx
  import rt_uart_pkg::*;
#(
  parameter int FifoDepth = 8,
  parameter int DivW      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_i,
  input  logic [DivW-1:0]            baud_div_i,
  input  logic                       parity_en_i,
  input  logic                       parity_odd_i,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       frame_err_o,
  output logic                       parity_err_o,
  output logic                       overrun_o,
  output logic [$clog2(FifoDepth):0] count_o
);
  localparam int OsW = $clog2(OversampleRate);
  localparam logic [OsW-1:0] SampleCnt = OsW'(SamplePoint);

  uart_state_e     r_state;
  uart_state_e     w_state_nxt;
  logic            r_sync1, r_sync2, r_rx_prev, r_armed;
  logic [1:0]      r_settle;
  logic [DivW-1:0] r_div, r_tick_cnt;
  logic            r_par_en, r_par_odd, r_par_bad;
  logic [OsW-1:0]  r_os_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_frame_err, r_parity_err, r_overrun;
  logic            w_rx, w_fall, w_tick, w_sample;
  logic            w_push, w_pop, w_full, w_empty;
  logic            w_frame_err, w_parity_err, w_overrun;

  assign w_rx     = r_sync2;
  assign w_fall   = r_armed && r_rx_prev && !w_rx;
  assign w_tick   = (r_tick_cnt == r_div);
  assign w_sample = w_tick && (r_os_cnt == SampleCnt);
  assign w_pop    = valid_o && ready_i;
  assign w_overrun = w_push && w_full && !w_pop;

  // Start edges are only trusted once the flushed synchronizer has shown a high line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_settle  <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_settle  <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_rx) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
    w_parity_err = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
      ST_START:  if (w_sample) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_sample && r_bit_cnt == 3'd7) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_sample) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_sample) begin
          if (!w_rx) begin
            w_frame_err = 1'b1;
            w_state_nxt = ST_BREAK;
          end else begin
            w_state_nxt = ST_IDLE;
            if (r_par_bad) w_parity_err = 1'b1;
            else           w_push       = 1'b1;
          end
        end
      end
      ST_BREAK:  if (w_rx) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // The edge-detect clock counts as oversample 0, so START resumes counting at 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_par_bad  <= 1'b0;
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else if (r_state == ST_IDLE) begin
      r_div      <= baud_div_i;
      r_par_en   <= parity_en_i;
      r_par_odd  <= parity_odd_i;
      r_par_bad  <= 1'b0;
      r_tick_cnt <= '0;
      r_os_cnt   <= OsW'(1);
      r_bit_cnt  <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) r_os_cnt <= r_os_cnt + 1'b1;
      if (w_sample && r_state == ST_DATA) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_sample && r_state == ST_PARITY) r_par_bad <= (w_rx != (^r_shift ^ r_par_odd));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_parity_err;
      r_overrun    <= w_overrun;
    end
  end

  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;
  assign valid_o      = !w_empty;

  rt_uart_rx_fifo #(
    .FifoDepth(FifoDepth),
    .Width    (8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .data_i (r_shift),
    .pop_i  (w_pop),
    .data_o (data_o),
    .full_o (w_full),
    .empty_o(w_empty),
    .count_o(count_o)
  );

endmodule

// File: tb/tb_rt_uart_rx.sv
// Self-checking bench for rt_uart_rx: frame table, corner sequences and random frames vs a queue model.
module tb_rt_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_div = '0;
  logic        par_en = 1'b0;
  logic        par_odd = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready = 1'b0;
  logic        frame_err_o, parity_err_o, overrun_o;
  logic [3:0]  count_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int rise_cyc = -1;
  bit prev_v = 1'b0;

  rt_uart_rx #(.FifoDepth(8), .DivW(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .baud_div_i  (baud_div),
    .parity_en_i (par_en),
    .parity_odd_i(par_odd),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .overrun_o   (overrun_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err_o)  fe_cnt++;
    if (parity_err_o) pe_cnt++;
    if (overrun_o)    ov_cnt++;
    if (valid_o && !prev_v) rise_cyc = cyc;
    prev_v = valid_o;
  end

  typedef struct packed {
    logic [7:0] d;
    bit pen; bit podd; bit pbit; bit stopb;
    bit exp_push; bit exp_fe; bit exp_pe;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input bit pen, input bit podd,
                            input bit pbit, input bit stopb);
    int bt;
    bt = 16 * (div + 1);
    baud_div = 16'(div);
    par_en = pen;
    par_odd = podd;
    rx = 1'b0;
    repeat (bt) step();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bt) step();
    end
    if (pen) begin
      rx = pbit;
      repeat (bt) step();
    end
    rx = stopb;
    repeat (bt) step();
    if (!stopb) repeat (40) step();
    rx = 1'b1;
    repeat (bt) step();
  endtask

  task automatic pop_check(input logic [7:0] exp);
    chk("pop_valid", 32'(valid_o), 32'd1);
    chk("pop_data", 32'(data_o), 32'(exp));
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    vec_t vt[9];
    logic [7:0] q[$];
    int fe0, pe0, ov0, t0;

    // reset state
    repeat (3) step();
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_errs", {29'd0, frame_err_o, parity_err_o, overrun_o}, 0);
    rst = 1'b0;
    repeat (10) step();

    // 0xA5, no parity, divisor 0: latency from the start edge
    t0 = cyc;
    send_frame(8'hA5, 0, 0, 0, 0, 1);
    chk("a5_latency_ok", 32'((rise_cyc - t0 >= 151) && (rise_cyc - t0 <= 155)), 1);
    chk("a5_count", 32'(count_o), 1);
    pop_check(8'hA5);

    // short low glitch is ignored, next byte still arrives
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    repeat (5) step();
    rx = 1'b1;
    repeat (40) step();
    chk("glitch_valid", 32'(valid_o), 0);
    chk("glitch_pulses", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 0);
    send_frame(8'h3C, 0, 0, 0, 0, 1);
    chk("after_glitch_count", 32'(count_o), 1);
    pop_check(8'h3C);

    // frame table: {data, par_en, odd, parity bit, stop bit, push, frame_err, parity_err}
    vt[0] = '{8'h01, 1, 0, 0, 1, 0, 0, 1};
    vt[1] = '{8'h01, 1, 0, 1, 1, 1, 0, 0};
    vt[2] = '{8'h03, 1, 1, 1, 1, 1, 0, 0};
    vt[3] = '{8'h03, 1, 1, 0, 1, 0, 0, 1};
    vt[4] = '{8'h80, 0, 0, 0, 1, 1, 0, 0};
    vt[5] = '{8'h55, 0, 0, 0, 0, 0, 1, 0};
    vt[6] = '{8'h0F, 0, 0, 0, 1, 1, 0, 0};
    vt[7] = '{8'h7E, 1, 0, 1, 1, 0, 0, 1};
    vt[8] = '{8'hFF, 1, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      send_frame(vt[i].d, 0, vt[i].pen, vt[i].podd, vt[i].pbit, vt[i].stopb);
      chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(vt[i].exp_push));
      chk($sformatf("tbl%0d_fe", i), 32'(fe_cnt - fe0), 32'(vt[i].exp_fe));
      chk($sformatf("tbl%0d_pe", i), 32'(pe_cnt - pe0), 32'(vt[i].exp_pe));
      chk($sformatf("tbl%0d_ov", i), 32'(ov_cnt - ov0), 0);
      if (vt[i].exp_push) pop_check(vt[i].d);
    end

    // fill past capacity with no consumer
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    for (int i = 0; i <= 8; i++) send_frame(8'(i), 0, 0, 0, 0, 1);
    chk("full_count", 32'(count_o), 8);
    chk("full_overrun", 32'(ov_cnt - ov0), 1);
    chk("full_other_errs", 32'((fe_cnt - fe0) + (pe_cnt - pe0)), 0);
    repeat (5) step();
    chk("stall_data", 32'(data_o), 0);
    for (int i = 0; i < 8; i++) pop_check(8'(i));
    chk("drained_count", 32'(count_o), 0);

    // reset in the middle of DATA with a byte already queued
    send_frame(8'h5A, 0, 0, 0, 0, 1);
    rx = 1'b0;
    repeat (16 + 16 * 3) step();
    rx = 1'b1;
    repeat (8) step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid_o), 0);
    chk("midrst_count", 32'(count_o), 0);
    chk("midrst_data", 32'(data_o), 0);
    chk("midrst_errs", {29'd0, frame_err_o, parity_err_o, overrun_o}, 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    send_frame(8'hC3, 0, 0, 0, 0, 1);
    chk("post_rst_count", 32'(count_o), 1);
    pop_check(8'hC3);

    // random frames against a queue model of the receive FIFO
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      int div, kind, k;
      bit pen, podd, pbit, stopb, e_fe, e_pe, e_push, e_ov;
      d = 8'($urandom);
      div = $urandom_range(0, 3);
      pen = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      stopb = (kind != 0);
      pbit = (^d) ^ podd ^ (kind == 1);
      e_fe = !stopb;
      e_pe = stopb && pen && (kind == 1);
      e_push = !e_fe && !e_pe;
      e_ov = e_push && (q.size() == 8);
      if (e_push && !e_ov) q.push_back(d);
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      send_frame(d, div, pen, podd, pbit, stopb);
      chk("rnd_fe", 32'(fe_cnt - fe0), 32'(e_fe));
      chk("rnd_pe", 32'(pe_cnt - pe0), 32'(e_pe));
      chk("rnd_ov", 32'(ov_cnt - ov0), 32'(e_ov));
      chk("rnd_count", 32'(count_o), 32'(q.size()));
      k = $urandom_range(0, q.size());
      for (int j = 0; j < k; j++) pop_check(q.pop_front());
    end
    while (q.size() > 0) pop_check(q.pop_front());
    chk("final_valid", 32'(valid_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rt_uart_rx.md
RT_UART_RX -- requirements
Module: rt_uart_rx

Interface
REQ-001 SHALL have parameter FifoDepth, default 8: receive FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter DivW, default 16: width of the baud divisor.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_i, input, 1: serial line, asynchronous to clk_i, idle high.
REQ-006 SHALL have port baud_div_i, input, DivW: oversample tick period minus 1; one bit time is 16*(baud_div_i+1) clocks.
REQ-007 SHALL have port parity_en_i, input, 1: expect a parity bit after the data bits.
REQ-008 SHALL have port parity_odd_i, input, 1: 1 selects odd parity, 0 selects even.
REQ-009 SHALL have port data_o, output, 8: FIFO head byte.
REQ-010 SHALL have port valid_o, output, 1: FIFO not empty.
REQ-011 SHALL have port ready_i, input, 1: consumer pops the head byte.
REQ-012 SHALL have port frame_err_o, output, 1: one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port parity_err_o, output, 1: one-cycle pulse on a parity mismatch.
REQ-014 SHALL have port overrun_o, output, 1: one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-015 SHALL have port count_o, output, $clog2(FifoDepth)+1: FIFO occupancy.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer that resets to 1; all decode SHALL use the synchronized value.
REQ-017 SHALL generate a tick every baud_div_i+1 clocks; the tick counter SHALL restart on leaving IDLE. baud_div_i and parity inputs SHALL be sampled only in IDLE.
REQ-018 SHALL implement the FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 IDLE SHALL go to START on a synchronized high-to-low transition.
REQ-020 START SHALL sample the line at oversample count 7; low goes to DATA, high (glitch) goes to IDLE with no output.
REQ-021 DATA SHALL sample each bit every 16 ticks at mid-bit, LSB first, 8 bits; it then goes to PARITY if parity_en_i is set, else to STOP.
REQ-022 PARITY SHALL sample one bit and compare it against the XOR of the data bits, inverted when odd parity is selected.
REQ-023 STOP, on sampling 1: a byte with good parity SHALL be pushed one clock after the sample.
REQ-024 STOP, on sampling 1 with a parity mismatch: the SHALL discard the byte and pulse parity_err_o; the FSM SHALL then go to IDLE at that sample point (half a stop bit early, for resync).
REQ-025 STOP, on sampling 0: the block SHALL pulse frame_err_o, discard the byte, and go to BREAK; BREAK SHALL wait for the synchronized line to go high, then go to IDLE.
REQ-026 When the FIFO is full and no pop occurs in the same cycle, a push SHALL drop the byte and pulse overrun_o, and the FIFO contents SHALL be unchanged.
REQ-027 A push and a pop in the same cycle SHALL both succeed at any occupancy, including full, with count_o unchanged.
REQ-028 A pop SHALL occur on valid_o && ready_i; data_o SHALL be stable while valid_o is high and ready_i is low.
REQ-029 Error pulses SHALL be mutually exclusive per frame; a parity error SHALL not also raise overrun_o.

Reset
REQ-030 Asserting rst_i at any time, including mid-frame, SHALL force: IDLE; FIFO empty; valid_o=0; count_o=0; data_o=0; all error pulses 0; synchronizer flops=1; tick counter=0.
REQ-031 After rst_i deasserts, a frame whose start edge begins mid-frame SHALL be ignored until the line is seen high for at least one clock.

Structure
REQ-032 Package rt_uart_pkg SHALL hold the FSM state enum, OversampleRate=16 and SamplePoint=7; it is shared with the future TX block.
REQ-033 The FIFO SHALL be a sub-module rt_uart_rx_fifo (parameters FifoDepth and width 8; push, pop, full, empty, count); everything else SHALL be flat.

Verification
REQ-034 Bench SHALL cover: baud_div_i=0, parity off, send 0xA5 -> valid_o rises with data_o=0xA5 at 153 ±2 clocks after the start edge, and count_o=1.
REQ-035 Bench SHALL cover: a 5-clock low glitch at baud_div_i=0 -> no valid_o and no error pulse; a following 0x3C is received correctly.
REQ-036 Bench SHALL cover: 0x55 with stop bit 0, line held low for 40 clocks -> one frame_err_o pulse, count_o stays 0, and the next 0x0F is received.
REQ-037 Bench SHALL cover: parity even, 0x01 sent with parity bit 0 -> one parity_err_o pulse and no push; 0x01 sent with parity bit 1 -> pushed.
REQ-038 Bench SHALL cover: ready_i=0, 9 bytes 0x00..0x08 -> count_o=8 and one overrun_o pulse; draining yields 0x00..0x07 in order.
REQ-039 Bench SHALL cover: rst_i pulsed in the middle of DATA -> all outputs reset at once; the next full frame 0xC3 is received correctly.
